ps2_kbd_rx: RTL and testbench

//  Receives the device-to-host PS/2 keyboard stream (ps2_kbd_clk_out/ps2_kbd_data_out

---
 rtl/ps2_kbd_rx_if.sv | 23 ++
 rtl/ps2_kbd_rx.sv | 215 +++++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_rx_if.sv
// Handshake and line bundle between the PS/2 keyboard receiver and its consumer.
// master = receiver side, slave = line driver / byte consumer side.
interface ps2_kbd_rx_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;
  logic       busy;

  modport master (
    input  ps2_clk, ps2_dat, rx_ready,
    output rx_data, rx_valid, parity_err, frame_err, overflow, busy
  );

  modport slave (
    output ps2_clk, ps2_dat, rx_ready,
    input  rx_data, rx_valid, parity_err, frame_err, overflow, busy
  );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: sync + deglitch both lines, frame start/8 data/odd parity/stop,
// and queue good bytes in a small first-word-fall-through FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a start bit (strobe with dat=0)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the parity bit
// S_STOP   | checking stop bit and parity, pushing the byte on success
module ps2_kbd_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic         clk_sys,
  input  logic         reset,
  ps2_kbd_rx_if.master bus
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = PW + 1;

  localparam logic [FCW-1:0] FCNT_INIT = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TMO_INIT  = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Internal reset: asserts with reset, releases two clocks after it drops.
  logic rst_meta_q, rst_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rst_meta_q <= 1'b1;
      rst_q      <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_q      <= rst_meta_q;
    end
  end

  // Line index 0 = ps2_clk, 1 = ps2_dat.
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     filt_q, filt_d;
  logic [FCW-1:0] fcnt_q [2];
  logic [FCW-1:0] fcnt_d [2];

  always_ff @(posedge clk_sys or posedge rst_q) begin
    if (rst_q) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      filt_q    <= 2'b11;
      fcnt_q[0] <= FCNT_INIT;
      fcnt_q[1] <= FCNT_INIT;
    end else begin
      sync1_q   <= {bus.ps2_dat, bus.ps2_clk};
      sync2_q   <= sync1_q;
      filt_q    <= filt_d;
      fcnt_q[0] <= fcnt_d[0];
      fcnt_q[1] <= fcnt_d[1];
    end
  end

  // Down-counter reloads whenever the synced level agrees with the filtered one.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = FCNT_INIT;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == '0) filt_d[i] = sync2_q[i];
        else                 fcnt_d[i] = fcnt_q[i] - FCW'(1);
      end
    end
  end

  logic strobe;
  logic bit_val;

  assign strobe  = filt_q[0] & ~filt_d[0];
  assign bit_val = filt_q[1];

  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           perr_q, perr_d;
  logic           ferr_q, ferr_d;
  logic           push;

  always_ff @(posedge clk_sys or posedge rst_q) begin
    if (rst_q) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      tmo_q     <= TMO_INIT;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    push      = 1'b0;

    if (strobe) tmo_d = TMO_INIT;
    else if (state_q != S_IDLE && tmo_q != '0) tmo_d = tmo_q - TCW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (strobe && !bit_val) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (strobe) begin
          shift_d   = {bit_val, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (strobe) begin
          par_d   = bit_val;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (strobe) begin
          if (!bit_val)               ferr_d = 1'b1;
          else if (^{shift_q, par_q}) push   = 1'b1;
          else                        perr_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-edge timeout abandons the partial frame.
    if (state_q != S_IDLE && !strobe && tmo_q == '0) begin
      ferr_d  = 1'b1;
      state_d = S_IDLE;
    end
  end

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          pop, full, push_ok;

  always_ff @(posedge clk_sys or posedge rst_q) begin
    if (rst_q) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    pop      = (count_q != '0) && bus.rx_ready;
    full     = (count_q == CW'(FIFO_DEPTH));
    push_ok  = push && (!full || pop);
    ovf_d    = push && full && !pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
  end

  assign bus.rx_valid   = (count_q != '0);
  assign bus.rx_data    = bus.rx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overflow   = ovf_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: directed frames plus random frames, scored against a queue-based
// model of which bytes must come out and which error pulses must appear.
module tb_ps2_kbd_rx;

  localparam int FL    = 4;
  localparam int TO    = 200;
  localparam int DEPTH = 4;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  ps2_kbd_rx_if bus();

  ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q [$];
  logic [7:0] pop_log [$];
  int exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
  int dut_perr = 0, dut_ferr = 0, dut_ovf = 0;
  bit stable = 1'b1;
  int cyc = 0;
  int edge_cyc = 0;
  int ferr_cyc = -1;
  logic perr_prev = 1'b0, ferr_prev = 1'b0, ovf_prev = 1'b0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  always @(posedge clk_sys) cyc++;

  // Compare process: FIFO view, pops, and error-pulse shape.
  always @(negedge clk_sys) begin
    int n_hi;
    logic [7:0] head;
    if (reset) begin
      chk({bus.rx_valid, bus.busy, bus.parity_err, bus.frame_err, bus.overflow} == 5'b0,
          "reset_flags", {bus.rx_valid, bus.busy, bus.parity_err, bus.frame_err, bus.overflow}, 0);
      chk(bus.rx_data == 8'h00, "reset_rx_data", bus.rx_data, 0);
    end else begin
      head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
      if (stable) begin
        chk(bus.rx_valid == (exp_q.size() != 0), "rx_valid", bus.rx_valid, exp_q.size() != 0);
        chk(bus.rx_data == head, "rx_data", bus.rx_data, head);
      end
      if (bus.rx_valid && bus.rx_ready) begin
        chk(exp_q.size() != 0, "pop_expected", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          chk(bus.rx_data == head, "pop_data", bus.rx_data, head);
          void'(exp_q.pop_front());
        end
        pop_log.push_back(bus.rx_data);
      end
      n_hi = int'(bus.parity_err) + int'(bus.frame_err) + int'(bus.overflow);
      if (n_hi != 0) chk(n_hi == 1, "err_exclusive", n_hi, 1);
      if (bus.parity_err) begin dut_perr++; chk(!perr_prev, "perr_width", 2, 1); end
      if (bus.frame_err)  begin dut_ferr++; ferr_cyc = cyc; chk(!ferr_prev, "ferr_width", 2, 1); end
      if (bus.overflow)   begin dut_ovf++;  chk(!ovf_prev, "ovf_width", 2, 1); end
    end
    perr_prev = bus.parity_err;
    ferr_prev = bus.frame_err;
    ovf_prev  = bus.overflow;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Outcome of a complete frame, decided from the frame rules alone.
  task automatic apply_model(input logic [7:0] d, input logic par, input logic stp);
    if (!stp) exp_ferr++;
    else if (($countones({d, par}) % 2) != 1) exp_perr++;
    else if (exp_q.size() >= DEPTH && !bus.rx_ready) exp_ovf++;
    else exp_q.push_back(d);
  endtask

  task automatic check_counts(input string tag);
    chk(dut_perr == exp_perr, {tag, "_perr_count"}, dut_perr, exp_perr);
    chk(dut_ferr == exp_ferr, {tag, "_ferr_count"}, dut_ferr, exp_ferr);
    chk(dut_ovf  == exp_ovf,  {tag, "_ovf_count"},  dut_ovf,  exp_ovf);
  endtask

  // One 40-cycle PS/2 bit: data set mid-high, clk low 20 cycles.
  task automatic send_bit(input logic b, input bit glitch);
    bus.ps2_dat = b;
    if (glitch) begin
      tick(3); bus.ps2_clk = 1'b0; tick(2); bus.ps2_clk = 1'b1; tick(5);
    end else tick(10);
    bus.ps2_clk = 1'b0;
    edge_cyc = cyc;
    tick(20);
    bus.ps2_clk = 1'b1;
    tick(10);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int glitch_bit, input string tag);
    logic [9:0] bits;
    bits = {par, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      send_bit(bits[i], glitch_bit == i);
      if (i == 0) chk(bus.busy == 1'b1, {tag, "_busy_mid"}, bus.busy, 1);
    end
    bus.ps2_dat = stp;
    tick(10);
    stable = 1'b0;
    apply_model(d, par, stp);
    bus.ps2_clk = 1'b0;
    edge_cyc = cyc;
    tick(20);
    bus.ps2_clk = 1'b1;
    tick(10);
    bus.ps2_dat = 1'b1;
    stable = 1'b1;
    tick(10);
    chk(bus.busy == 1'b0, {tag, "_busy_idle"}, bus.busy, 0);
    check_counts(tag);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int ferr_before;
    int lat;
    int n;
    logic [7:0] d;
    int kind;

    bus.ps2_clk  = 1'b1;
    bus.ps2_dat  = 1'b1;
    bus.rx_ready = 1'b1;
    reset = 1'b1;
    tick(5);
    reset = 1'b0;
    tick(10);

    // 1: good 0x1C
    send_frame(8'h1C, 1'b0, 1'b1, -1, "t1");
    chk(pop_log.size() == 1, "t1_pop_count", pop_log.size(), 1);
    if (pop_log.size() == 1) chk(pop_log[0] == 8'h1C, "t1_byte", pop_log[0], 8'h1C);

    // 2: 0xF0 with wrong parity
    send_frame(8'hF0, 1'b0, 1'b1, -1, "t2");
    chk(dut_perr == 1, "t2_perr_literal", dut_perr, 1);
    chk(pop_log.size() == 1, "t2_no_push", pop_log.size(), 1);

    // 3: bad stop, then the same byte cleanly
    send_frame(8'h5A, 1'b1, 1'b0, -1, "t3a");
    chk(dut_ferr == 1, "t3_ferr_literal", dut_ferr, 1);
    send_frame(8'h5A, 1'b1, 1'b1, -1, "t3b");
    chk(pop_log.size() == 2 && pop_log[pop_log.size()-1] == 8'h5A, "t3_byte",
        pop_log[pop_log.size()-1], 8'h5A);

    // 4: fill, overflow on the fifth, then drain in order
    bus.rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send_frame(d, good_par(d), 1'b1, -1, "t4");
    end
    chk(dut_ovf == 1, "t4_ovf_literal", dut_ovf, 1);
    n = pop_log.size();
    bus.rx_ready = 1'b1;
    tick(10);
    chk(pop_log.size() == n + 4, "t4_pop_count", pop_log.size(), n + 4);
    for (int i = 0; i < 4; i++)
      if (pop_log.size() > n + i) chk(pop_log[n+i] == 8'(i + 1), "t4_order", pop_log[n+i], i + 1);
    chk(bus.rx_valid == 1'b0, "t4_empty", bus.rx_valid, 0);

    // 5: start + 4 data bits, then silence until timeout
    ferr_before = dut_ferr;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    chk(bus.busy == 1'b1, "t5_busy_partial", bus.busy, 1);
    exp_ferr++;
    tick(300);
    chk(dut_ferr == ferr_before + 1, "t5_timeout_pulse", dut_ferr, ferr_before + 1);
    lat = ferr_cyc - edge_cyc;
    chk(lat >= TO && lat <= TO + FL + 4, "t5_timeout_latency", lat, TO + FL + 2);
    chk(bus.busy == 1'b0, "t5_busy_after", bus.busy, 0);
    send_frame(8'h33, 1'b1, 1'b1, -1, "t5");
    chk(pop_log[pop_log.size()-1] == 8'h33, "t5_byte", pop_log[pop_log.size()-1], 8'h33);

    // 6: clock glitches idle and mid-frame, then reset mid-frame
    bus.ps2_clk = 1'b0; tick(2); bus.ps2_clk = 1'b1; tick(20);
    chk(bus.busy == 1'b0, "t6_idle_glitch", bus.busy, 0);
    send_frame(8'hA7, good_par(8'hA7), 1'b1, 4, "t6g");
    chk(pop_log[pop_log.size()-1] == 8'hA7, "t6_glitch_byte", pop_log[pop_log.size()-1], 8'hA7);

    bus.rx_ready = 1'b0;
    send_frame(8'h2B, 1'b1, 1'b1, -1, "t6h");
    chk(bus.rx_valid == 1'b1, "t6_held", bus.rx_valid, 1);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    stable = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    tick(4);
    reset = 1'b0;
    stable = 1'b1;
    tick(20);
    chk(bus.rx_valid == 1'b0, "t6_reset_empty", bus.rx_valid, 0);
    chk(bus.busy == 1'b0, "t6_reset_idle", bus.busy, 0);
    bus.rx_ready = 1'b1;
    tick(2);
    n = pop_log.size();
    send_frame(8'h1C, 1'b0, 1'b1, -1, "t6");
    chk(pop_log.size() == n + 1 && pop_log[pop_log.size()-1] == 8'h1C, "t6_byte",
        pop_log[pop_log.size()-1], 8'h1C);

    // Random frames: mixed good/bad, random back-pressure, occasional glitch.
    for (int f = 0; f < 40; f++) begin
      bus.rx_ready = 1'($urandom_range(0, 1));
      tick(5);
      kind = $urandom_range(0, 9);
      d    = 8'($urandom);
      send_frame(d, good_par(d) ^ (kind == 0), (kind != 1),
                 (kind == 2) ? $urandom_range(0, 9) : -1, "rnd");
    end

    bus.rx_ready = 1'b1;
    tick(10);
    chk(exp_q.size() == 0, "drain_model", exp_q.size(), 0);
    chk(bus.rx_valid == 1'b0, "drain_dut", bus.rx_valid, 0);
    check_counts("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
